// File: rtl/branch_pc_unit_pkg.sv
// Shared constants and FSM encoding for the fetch-PC / next-PC selector.
package branch_pc_unit_pkg;
  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} pc_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP      = 32'd4;
endpackage

// File: rtl/npc_target_calc.sv
// Combinational br/j/jr target computation with jr > jump > branch priority.
module npc_target_calc
  import branch_pc_unit_pkg::*;
(
  input  logic [31:0] pc_id,
  input  logic        branch,
  input  logic        branch_used,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] rs_val,
  output logic        take,
  output logic [31:0] target
);
  logic [31:0] pc_plus4, br_tgt, j_tgt;

  assign pc_plus4 = pc_id + PC_STEP;
  assign br_tgt   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  // Jump region comes from the delay-slot PC, not the jump's own PC.
  assign j_tgt    = {pc_plus4[31:28], instr_index, 2'b00};
  assign take     = jr | jump | (branch & branch_used);

  always_comb begin
    target = br_tgt;
    if (jr)        target = rs_val;
    else if (jump) target = j_tgt;
  end
endmodule

// File: rtl/branch_pc_unit.sv
// Fetch-PC register with redirect selection; parks a redirect while fetch is held.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          DELAY_SLOT = 1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_stall_i,
  input  logic             if_hold_i,
  input  logic [31:0]      pc_id_i,
  input  logic             branch_i,
  input  logic             branch_used_i,
  input  logic [15:0]      imm16_i,
  input  logic             jump_i,
  input  logic [25:0]      instr_index_i,
  input  logic             jr_i,
  input  logic [31:0]      rs_val_i,
  output logic [31:0]      pc_if_o,
  output logic             redirect_o,
  output logic             flush_id_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] taken_cnt_o
);
  pc_state_e   state, state_nxt;
  logic [31:0] pc_q, pc_nxt, tgt_q, tgt_nxt, target;
  logic        take, decision, apply;
  logic [CNT_W-1:0] cnt_q;

  npc_target_calc u_calc (
    .pc_id       (pc_id_i),
    .branch      (branch_i),
    .branch_used (branch_used_i),
    .imm16       (imm16_i),
    .jump        (jump_i),
    .instr_index (instr_index_i),
    .jr          (jr_i),
    .rs_val      (rs_val_i),
    .take        (take),
    .target      (target)
  );

  assign decision = !id_stall_i && take;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    tgt_nxt   = tgt_q;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (decision) begin
          if (if_hold_i) begin
            tgt_nxt   = target;
            state_nxt = PENDING;
          end else begin
            pc_nxt = target;
            apply  = 1'b1;
          end
        end else if (!id_stall_i && !if_hold_i) begin
          pc_nxt = pc_q + PC_STEP;
        end
      end
      PENDING: begin
        // A parked redirect wins over whatever ID is showing now, stalled or not.
        if (!if_hold_i) begin
          pc_nxt    = tgt_q;
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      redirect_o <= 1'b0;
      flush_id_o <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      tgt_q      <= tgt_nxt;
      redirect_o <= apply;
      flush_id_o <= (DELAY_SLOT == 0) ? apply : 1'b0;
      if (apply && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pc_if_o     = pc_q;
  assign pending_o   = (state == PENDING);
  assign taken_cnt_o = cnt_q;
endmodule
